sdram_arbiter: RTL

- Shares one Avalon-MM SDRAM master port among NUM_PORTS shader-core SDRAM interfaces, for multi-core GPU builds.
- Sits between the per-core sdram_* buses and the top-level SDRAM controller.
- Arbitrates commands round-robin and holds the grant while waitrequest stalls.
- Tracks outstanding pipelined reads so each readdatavalid returns to the requester that issued the read.

---
 rtl/sdram_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SDRAM master among several requesters.
// Holds the grant through waitrequest stalls and routes in-order read returns back by ID.
module sdram_arbiter #(
  parameter int unsigned NUM_PORTS           = 4,
  parameter int unsigned WORD_WIDTH          = 32,
  parameter int unsigned SDRAM_ADDRESS_WIDTH = 24,
  parameter int unsigned MAX_OUTSTANDING     = 8,
  parameter int unsigned ID_WIDTH            = $clog2(NUM_PORTS)
) (
  input  logic                                     clock,
  input  logic                                     reset_n,
  input  logic [NUM_PORTS*SDRAM_ADDRESS_WIDTH-1:0] req_address,
  input  logic [NUM_PORTS-1:0]                     req_read,
  input  logic [NUM_PORTS-1:0]                     req_write,
  input  logic [NUM_PORTS*WORD_WIDTH-1:0]          req_writedata,
  output logic [NUM_PORTS-1:0]                     req_waitrequest,
  output logic [WORD_WIDTH-1:0]                    req_readdata,
  output logic [NUM_PORTS-1:0]                     req_readdatavalid,
  output logic [SDRAM_ADDRESS_WIDTH-1:0]           sdram_address,
  output logic                                     sdram_read,
  output logic                                     sdram_write,
  output logic [WORD_WIDTH-1:0]                    sdram_writedata,
  input  logic                                     sdram_waitrequest,
  input  logic [WORD_WIDTH-1:0]                    sdram_readdata,
  input  logic                                     sdram_readdatavalid,
  output logic [$clog2(MAX_OUTSTANDING):0]         outstanding_count,
  output logic                                     protocol_error
);

  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {GRANT_FREE, GRANT_HELD} grant_state_t;

  grant_state_t                   state, state_next;
  logic [ID_WIDTH-1:0]            last_grant;
  logic [ID_WIDTH-1:0]            locked_id;
  logic [SDRAM_ADDRESS_WIDTH-1:0] addr_arr [NUM_PORTS];
  logic [WORD_WIDTH-1:0]          wdata_arr [NUM_PORTS];
  logic [ID_WIDTH-1:0]            id_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0]               wr_ptr, rd_ptr;

  logic [NUM_PORTS-1:0] req_any, eligible;
  logic                 slot_free, held_valid, lock_drop;
  logic                 rr_found, has_win;
  logic [ID_WIDTH-1:0]  rr_id, scan_id, win_id;
  logic                 cmd, accept, stall, push, pop, fifo_empty;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign addr_arr[g]  = req_address[g*SDRAM_ADDRESS_WIDTH +: SDRAM_ADDRESS_WIDTH];
    assign wdata_arr[g] = req_writedata[g*WORD_WIDTH +: WORD_WIDTH];
  end

  // A port issuing both read and write is treated as a read.
  assign req_any    = req_read | req_write;
  assign slot_free  = outstanding_count < CNT_W'(MAX_OUTSTANDING);
  assign fifo_empty = (outstanding_count == '0);

  always_comb begin
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      eligible[i] = req_read[i] ? slot_free : req_write[i];
    end
  end

  // Round-robin scan starting just after the last granted port.
  always_comb begin
    rr_found = 1'b0;
    rr_id    = '0;
    scan_id  = '0;
    for (int k = 1; k <= int'(NUM_PORTS); k++) begin
      scan_id = ID_WIDTH'((int'(last_grant) + k) % int'(NUM_PORTS));
      if (!rr_found && eligible[scan_id]) begin
        rr_found = 1'b1;
        rr_id    = scan_id;
      end
    end
  end

  assign held_valid = (state == GRANT_HELD) && req_any[locked_id];
  assign lock_drop  = (state == GRANT_HELD) && !req_any[locked_id];
  assign has_win    = reset_n && (held_valid || rr_found);
  assign win_id     = held_valid ? locked_id : rr_id;

  always_comb begin
    sdram_read      = 1'b0;
    sdram_write     = 1'b0;
    sdram_address   = '0;
    sdram_writedata = '0;
    req_waitrequest = '1;
    if (has_win) begin
      sdram_read              = req_read[win_id];
      sdram_write             = !req_read[win_id] && req_write[win_id];
      sdram_address           = addr_arr[win_id];
      sdram_writedata         = wdata_arr[win_id];
      req_waitrequest[win_id] = sdram_waitrequest;
    end
  end

  assign cmd    = sdram_read || sdram_write;
  assign accept = cmd && !sdram_waitrequest;
  assign stall  = cmd && sdram_waitrequest;
  assign push   = accept && sdram_read;
  assign pop    = sdram_readdatavalid && !fifo_empty;

  // Grant stays locked only while the controller stalls the presented command.
  always_comb begin
    state_next = GRANT_FREE;
    if (stall) begin
      state_next = GRANT_HELD;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= GRANT_FREE;
      locked_id  <= '0;
      last_grant <= ID_WIDTH'(NUM_PORTS - 1);
    end else begin
      state <= state_next;
      if (stall) begin
        locked_id <= win_id;
      end
      if (accept) begin
        last_grant <= win_id;
      end
    end
  end

  // Read-return ID FIFO; returns are in order so the head owns the next strobe.
  always_ff @(posedge clock) begin
    if (push) begin
      id_fifo[wr_ptr] <= win_id;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      outstanding_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   outstanding_count <= outstanding_count + CNT_W'(1);
        2'b01:   outstanding_count <= outstanding_count - CNT_W'(1);
        default: outstanding_count <= outstanding_count;
      endcase
    end
  end

  assign req_readdata = sdram_readdata;

  always_comb begin
    req_readdatavalid = '0;
    if (pop) begin
      req_readdatavalid[id_fifo[rd_ptr]] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      protocol_error <= 1'b0;
    end else if ((|(req_read & req_write)) || lock_drop || (sdram_readdatavalid && fifo_empty)) begin
      protocol_error <= 1'b1;
    end
  end

endmodule
